simon_round_ctrl: RTL and testbench

- Control FSM that sequences an iterative Simon round/key-schedule datapath (one round per clock) for all 10 standard Simon block/key-size variants.
- Handles the host request/response handshake, latches the variant and drives the datapath strobes.
- Supplies round index, round count and the per-round z-sequence constant bit.
- Sits between the host/bus wrapper and the Simon round core; no data words pass through it.

---
 rtl/simon_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_simon_round_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_ctrl.sv
// rtl/simon_round_ctrl.sv - sequencing FSM for an iterative Simon round/key-schedule datapath
module simon_round_ctrl #(
   parameter logic [9:0] MODE_MASK = 10'h3FF,
   parameter int         Z_WIDTH   = 62
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_mode,
   input  logic       abort,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_err,
   output logic       dp_load,
   output logic       dp_round_en,
   output logic [6:0] dp_round_idx,
   output logic       dp_zbit,
   output logic [2:0] dp_word_sel,
   output logic [2:0] dp_m,
   output logic       busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [6:0] ZW = 7'(Z_WIDTH);

   // Modes 10..15 never exist, so they sit above the enable mask as zeros.
   localparam logic [15:0] VALID_MASK = {6'b0, MODE_MASK};

   // Leftmost character of each published z string is bit 61 here.
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
   localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

   logic [1:0]  state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [3:0]  mode_q, mode_d;
   logic        err_q, err_d;

   logic [2:0]  tab_wsel;
   logic [2:0]  tab_m;
   logic [6:0]  tab_last;
   logic [2:0]  tab_z;
   logic [61:0] z_word;
   logic [6:0]  idx_mod;
   logic [6:0]  z_pos;
   logic        mode_ok;

   // Variant table lookup for the latched mode: word size code, key words, last round index, z sequence.
   always_comb begin
      tab_wsel = 3'd0;
      tab_m    = 3'd0;
      tab_last = 7'd0;
      tab_z    = 3'd0;
      case (mode_q)
         4'd0: begin tab_wsel = 3'd0; tab_m = 3'd4; tab_last = 7'd31; tab_z = 3'd0; end
         4'd1: begin tab_wsel = 3'd1; tab_m = 3'd3; tab_last = 7'd35; tab_z = 3'd0; end
         4'd2: begin tab_wsel = 3'd1; tab_m = 3'd4; tab_last = 7'd35; tab_z = 3'd1; end
         4'd3: begin tab_wsel = 3'd2; tab_m = 3'd3; tab_last = 7'd41; tab_z = 3'd2; end
         4'd4: begin tab_wsel = 3'd2; tab_m = 3'd4; tab_last = 7'd43; tab_z = 3'd3; end
         4'd5: begin tab_wsel = 3'd3; tab_m = 3'd2; tab_last = 7'd51; tab_z = 3'd2; end
         4'd6: begin tab_wsel = 3'd3; tab_m = 3'd3; tab_last = 7'd53; tab_z = 3'd3; end
         4'd7: begin tab_wsel = 3'd4; tab_m = 3'd2; tab_last = 7'd67; tab_z = 3'd2; end
         4'd8: begin tab_wsel = 3'd4; tab_m = 3'd3; tab_last = 7'd68; tab_z = 3'd3; end
         4'd9: begin tab_wsel = 3'd4; tab_m = 3'd4; tab_last = 7'd71; tab_z = 3'd4; end
         default: begin tab_wsel = 3'd0; tab_m = 3'd0; tab_last = 7'd0; tab_z = 3'd0; end
      endcase
   end

   // z constant bit for the current round; indices past the period wrap back to the start.
   always_comb begin
      case (tab_z)
         3'd0:    z_word = Z0;
         3'd1:    z_word = Z1;
         3'd2:    z_word = Z2;
         3'd3:    z_word = Z3;
         3'd4:    z_word = Z4;
         default: z_word = Z0;
      endcase
      idx_mod = (cnt_q >= ZW) ? (cnt_q - ZW) : cnt_q;
      z_pos   = ZW - 7'd1 - idx_mod;
   end

   // Next-state, round counter, mode latch and error flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mode_d = in_mode;
               cnt_d  = 7'd0;
               if (VALID_MASK[in_mode]) begin
                  state_d = S_LOAD;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         S_LOAD: begin
            cnt_d = 7'd0;
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               cnt_d   = 7'd0;
            end else if (cnt_q == tab_last) begin
               state_d = S_DONE;
               err_d   = 1'b0;
               cnt_d   = 7'd0;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 7'd0;
         mode_q  <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from state; datapath config is blanked in IDLE and for rejected modes.
   always_comb begin
      mode_ok      = VALID_MASK[mode_q] && (state_q != S_IDLE);
      in_ready     = rst_n && (state_q == S_IDLE);
      out_valid    = (state_q == S_DONE);
      out_err      = (state_q == S_DONE) && err_q;
      dp_load      = (state_q == S_LOAD);
      dp_round_en  = (state_q == S_RUN);
      dp_round_idx = (state_q == S_RUN) ? cnt_q : 7'd0;
      dp_zbit      = (state_q == S_RUN) && z_word[z_pos[5:0]];
      dp_word_sel  = mode_ok ? tab_wsel : 3'd0;
      dp_m         = mode_ok ? tab_m : 3'd0;
      busy         = (state_q == S_LOAD) || (state_q == S_RUN);
   end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb/tb_simon_round_ctrl.sv - scoreboard testbench for simon_round_ctrl
module tb_simon_round_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, abort, out_valid, out_ready, out_err;
   logic [3:0] in_mode;
   logic       dp_load, dp_round_en, dp_zbit, busy;
   logic [6:0] dp_round_idx;
   logic [2:0] dp_word_sel, dp_m;

   logic       b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready, b_out_err;
   logic [3:0] b_in_mode;
   logic       b_dp_load, b_dp_round_en, b_dp_zbit, b_busy;
   logic [6:0] b_dp_round_idx;
   logic [2:0] b_dp_word_sel, b_dp_m;

   always #5 clk = ~clk;

   simon_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
      .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
      .dp_zbit(dp_zbit), .dp_word_sel(dp_word_sel), .dp_m(dp_m), .busy(busy)
   );

   simon_round_ctrl #(.MODE_MASK(10'h3FE)) dut_masked (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
      .abort(b_abort), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_err(b_out_err),
      .dp_load(b_dp_load), .dp_round_en(b_dp_round_en), .dp_round_idx(b_dp_round_idx),
      .dp_zbit(b_dp_zbit), .dp_word_sel(b_dp_word_sel), .dp_m(b_dp_m), .busy(b_busy)
   );

   // Reference tables straight from the variant list.
   int    T_TAB[10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
   int    N_TAB[10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
   int    M_TAB[10] = '{4, 3, 4, 3, 4, 2, 3, 2, 3, 4};
   int    J_TAB[10] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 4};
   string ZS[5] = '{
      "11111010001001010110000111001101111101000100101011000011100110",
      "10001110111110010011000010110101000111011111001001100001011010",
      "10101111011100000011010010011000101000010001111110010110110011",
      "11011011101011000110010111100000010010001010011100110100001111",
      "11010001111001101011011000100000010111000011001010010011101111"};

   typedef struct {
      int mode;
      bit err;
      int rounds;
      bit load;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wsel_of(input int n);
      case (n)
         16: return 0;
         24: return 1;
         32: return 2;
         48: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic bit zbit_of(input int mode, input int idx);
      byte c;
      c = ZS[J_TAB[mode]].getc(idx % 62);
      return (c == "1");
   endfunction

   // Monitor: observes strobes and the response handshake, checks against the queued expectation.
   int   obs_rounds, obs_load, cyc, first_ov;
   bit   prev_ov, prev_hs;
   exp_t e;
   initial begin
      obs_rounds = 0; obs_load = 0; cyc = 0; first_ov = -1; prev_ov = 0; prev_hs = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            obs_rounds = 0; obs_load = 0; cyc = 0; first_ov = -1; prev_ov = 0; prev_hs = 0;
         end else begin
            cyc++;
            if (in_valid && in_ready) begin
               cyc = 0; obs_rounds = 0; obs_load = 0; first_ov = -1;
            end
            if (in_ready && out_valid) chk("ready_and_valid", 1, 0);
            if (in_ready)
               chk("idle_outputs", {out_valid, out_err, dp_load, dp_round_en, dp_round_idx,
                                    dp_zbit, dp_word_sel, dp_m, busy}, 0);
            if (out_err && !out_valid) chk("err_without_valid", 1, 0);
            if (prev_ov && !prev_hs && !out_valid) chk("out_valid_dropped", 1, 0);
            if (out_valid)
               chk("done_strobes", {dp_load, dp_round_en, dp_round_idx, dp_zbit, busy}, 0);
            if (dp_load || dp_round_en) begin
               if (sb.size() == 0) chk("strobe_without_request", 1, 0);
               else begin
                  e = sb[0];
                  chk("word_sel", dp_word_sel, wsel_of(N_TAB[e.mode]));
                  chk("key_words", dp_m, M_TAB[e.mode]);
                  chk("busy", busy, 1);
                  if (dp_load) begin
                     obs_load++;
                     chk("load_idx", dp_round_idx, 0);
                  end else begin
                     chk("round_idx", dp_round_idx, obs_rounds);
                     chk("zbit", dp_zbit, zbit_of(e.mode, obs_rounds));
                     obs_rounds++;
                  end
               end
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) chk("response_without_request", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("out_err", out_err, e.err);
                  chk("round_count", obs_rounds, e.rounds);
                  chk("load_count", obs_load, e.load);
                  chk("latency", first_ov, e.load ? e.rounds + 2 : 1);
               end
            end
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
         end
      end
   end

   task automatic wait_for(input string name, input int which);
      int n;
      n = 0;
      while (((which == 0) ? !in_ready : !out_valid) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 300) chk(name, 0, 1);
   endtask

   // Issue one request; abort_at: -1 none, -2 during LOAD, k>=0 during round k.
   task automatic req(input int mode, input int abort_at, input int stall);
      exp_t x;
      bit   v;
      v = (mode < 10);
      if (!v) abort_at = -1;
      x.mode   = v ? mode : 0;
      x.load   = v;
      x.err    = !v || (abort_at != -1);
      x.rounds = !v ? 0 : (abort_at == -2) ? 0 : (abort_at >= 0) ? abort_at + 1 : T_TAB[mode];
      sb.push_back(x);
      wait_for("timeout_in_ready", 0);
      in_valid = 1'b1; in_mode = 4'(mode); out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_mode = 4'($urandom);
      if (abort_at == -2) begin
         abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
      end else if (abort_at >= 0) begin
         repeat (abort_at + 1) @(posedge clk);
         #1; abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
      end
      wait_for("timeout_out_valid", 1);
      in_valid = (stall > 0);
      for (int i = 0; i < stall; i++) begin
         in_mode = 4'($urandom);
         abort   = 1'($urandom);
         @(posedge clk); #1;
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("back_to_idle", in_ready, 1);
   endtask

   initial begin
      int   mode, ab, r;
      exp_t x;
      rst_n = 1'b0; in_valid = 0; in_mode = 0; abort = 0; out_ready = 0;
      b_in_valid = 0; b_in_mode = 0; b_abort = 0; b_out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {in_ready, out_valid, out_err, dp_load, dp_round_en, dp_round_idx,
                            dp_zbit, dp_word_sel, dp_m, busy}, 0);
      rst_n = 1'b1;
      #1;
      chk("reset_in_ready", in_ready, 1);

      req(0, -1, 0);
      req(9, -1, 0);
      req(12, -1, 0);
      req(4, 20, 0);
      req(4, -1, 0);
      req(7, -1, 10);
      req(3, -2, 0);
      req(1, 35, 1);

      // Mid-run reset: mode 5 reaches round 30, then reset drops it with no response.
      x.mode = 5; x.load = 1; x.err = 0; x.rounds = 52;
      sb.push_back(x);
      wait_for("timeout_in_ready", 0);
      in_valid = 1'b1; in_mode = 4'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (31) @(posedge clk);
      #1;
      chk("pre_reset_idx", dp_round_idx, 30);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_reset_outputs", {in_ready, out_valid, out_err, dp_load, dp_round_en, dp_round_idx,
                                dp_zbit, dp_word_sel, dp_m, busy}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post_reset_ready", in_ready, 1);
      repeat (8) @(posedge clk);
      #1;

      // Masked instance: mode 0 disabled, mode 1 still runs.
      chk("masked_ready", b_in_ready, 1);
      b_in_valid = 1'b1; b_in_mode = 4'd0;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("masked_reject", {b_out_valid, b_out_err, b_dp_load, b_dp_round_en}, 4'b1100);
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      chk("masked_idle", {b_in_ready, b_out_valid}, 2'b10);
      b_in_valid = 1'b1; b_in_mode = 4'd1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("masked_mode1_load", {b_dp_load, b_dp_word_sel, b_dp_m}, {1'b1, 3'd1, 3'd3});
      repeat (37) @(posedge clk);
      #1;
      chk("masked_mode1_done", {b_out_valid, b_out_err}, 2'b10);
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;

      // Randomized requests: any mode, occasional aborts (including on the last round) and stalls.
      for (int k = 0; k < 40; k++) begin
         mode = $urandom_range(0, 15);
         r    = $urandom_range(0, 3);
         ab   = -1;
         if (mode < 10) begin
            if (r == 0) ab = $urandom_range(0, T_TAB[mode] - 1);
            else if (r == 1) ab = ($urandom_range(0, 1) == 0) ? -2 : T_TAB[mode] - 1;
         end
         req(mode, ab, $urandom_range(0, 3));
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
